// File: rtl/fir_decim_fifo.sv
// Decimating FIFO behind the 10-tap FIR stage.
// Keeps one filter sample in every DECIM and buffers the kept samples.
// The kept samples are presented on a first-word-fall-through valid/ready stream.
// A kept sample that arrives while the FIFO is full and not draining is dropped.
// Such a drop sets a sticky overflow flag.
module fir_decim_fifo #(
    parameter int W     = 16,
    parameter int DECIM = 4,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1,
    localparam int PW   = (DECIM > 1) ? $clog2(DECIM) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W-1:0]  y_in,
    input  logic          in_en,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic [PW-1:0] phase,
    output logic          overflow
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          keep;
    logic          full;
    logic          pop;
    logic          push;

    assign keep      = in_en && (phase == '0);
    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // When the FIFO is full, a pop in the same cycle frees the slot that the push needs.
    assign push      = keep && (!full || pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Sample storage; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem[wr_ptr] <= y_in;
        end
    end

    // Decimation phase counter, advancing only on valid filter samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= '0;
        end else if (in_en) begin
            if (phase == PW'(DECIM - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (keep && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo with W=16, DECIM=4, DEPTH=8.
module tb_fir_decim_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] y_in;
    logic        in_en;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic [1:0]  phase;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    fir_decim_fifo #(.W(16), .DECIM(4), .DEPTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .y_in      (y_in),
        .in_en     (in_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .phase     (phase),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock one edge, settle 1 time unit past the edge.
    task automatic step(input logic e, input logic [15:0] y, input logic r);
        in_en     = e;
        y_in      = y;
        out_ready = r;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int exp_phase;
        int exp_cnt;
        logic [15:0] exp_q [$];
        reset     = 1'b1;
        in_en     = 1'b0;
        y_in      = '0;
        out_ready = 1'b0;
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);

        // reset state
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_phase", phase, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;

        // basic decimation, consumer always ready
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 16'(i), 1'b1);
            chk("basic_cnt_le1", 32'(count <= 4'd1), 1);
            chk("basic_valid", out_valid, 32'((i % 4) == 1));
            if ((i % 4) == 1) chk("basic_data", out_data, i);
        end
        chk("basic_ovf", overflow, 0);
        chk("basic_phase", phase, 0);

        // in_en gaps
        do_reset();
        exp_phase = 0;
        begin
            logic [8:0] pat;
            pat = 9'b111_011_001;
            for (int c = 0; c < 9; c++) begin
                step(pat[c], 16'(10 + c), 1'b0);
                if (pat[c]) exp_phase = (exp_phase + 1) % 4;
                chk("gap_phase", phase, exp_phase);
            end
        end
        chk("gap_count", count, 2);
        chk("gap_head0", out_data, 10);
        step(1'b0, 16'h0, 1'b1);
        chk("gap_head1", out_data, 17);
        step(1'b0, 16'h0, 1'b1);
        chk("gap_empty", out_valid, 0);

        // stall to full, drop, and backpressure stability
        do_reset();
        for (int i = 1; i <= 36; i++) begin
            step(1'b1, 16'(i), 1'b0);
            exp_cnt = (i - 1) / 4 + 1;
            if (exp_cnt > 8) exp_cnt = 8;
            chk("stall_count", count, exp_cnt);
            chk("stall_data", out_data, 1);
            chk("stall_ovf", overflow, 32'(i >= 33));
        end
        for (int k = 0; k < 8; k++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, 1 + 4 * k);
            step(1'b0, 16'h0, 1'b1);
        end
        chk("drain_empty", out_valid, 0);
        chk("drain_data0", out_data, 0);
        chk("drain_ovf", overflow, 1);

        // full with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 32; i++) step(1'b1, 16'(100 + i), 1'b0);
        chk("fpp_full", count, 8);
        chk("fpp_phase", phase, 0);
        step(1'b1, 16'h0AAA, 1'b1);
        chk("fpp_count", count, 8);
        chk("fpp_ovf", overflow, 0);
        for (int k = 1; k < 8; k++) exp_q.push_back(16'(101 + 4 * k));
        exp_q.push_back(16'h0AAA);
        for (int k = 0; k < 8; k++) begin
            chk("fpp_data", out_data, exp_q[k]);
            step(1'b0, 16'h0, 1'b1);
        end
        chk("fpp_empty", out_valid, 0);

        // reset mid-operation, then bit-exact extreme values
        do_reset();
        for (int i = 1; i <= 33; i++) step(1'b1, 16'(i), 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h1234, 1'b0);
        chk("mid_count", count, 5);
        chk("mid_ovf", overflow, 1);
        chk("mid_phase", phase, 2);
        reset = 1'b1;
        step(1'b1, 16'h5555, 1'b1);
        reset = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_phase", phase, 0);
        chk("mid_rst_ovf", overflow, 0);
        step(1'b1, 16'h8000, 1'b0);
        chk("neg_data", out_data, 16'h8000);
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h0002, 1'b0);
        step(1'b1, 16'h0003, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        chk("ext_count", count, 2);
        chk("ext_head", out_data, 16'h8000);
        step(1'b0, 16'h0, 1'b1);
        chk("ext_ffff", out_data, 16'hFFFF);
        step(1'b0, 16'h0, 1'b1);
        chk("ext_empty", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
- Sits directly downstream of the 10-tap FIR stage.
- Takes the filter's registered W-bit two's-complement output every cycle the filter advances and keeps one sample in DECIM.
- Buffers kept samples in a small FIFO and presents them on a valid/ready stream to the consumer (DAC serializer / host readout).
- Detects and flags overflow when the consumer stalls too long.

Parameters:
- W, 16: sample width; matches the filter output width.
- DECIM, 4: decimation factor, >= 1; DECIM = 1 keeps every sample.
- DEPTH, 8: FIFO depth in samples, power of two, >= 2.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- y_in  input  W  filter output sample, two's complement
- in_en  input  1  high on cycles where y_in holds a new filter sample
- out_data  output  W  head-of-FIFO sample
- out_valid  output  1  out_data holds a valid sample
- out_ready  input  1  consumer accepts out_data this cycle
- count  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- phase  output  $clog2(DECIM) (min 1)  decimation phase counter
- overflow  output  1  sticky flag: a kept sample was dropped

Behaviour:
- Reset: reset is synchronous, active-high; clock is clock. On reset, phase, read pointer, write pointer, count and overflow clear to 0, so out_valid = 0 and out_data = 0. Memory contents are not reset. Reset overrides all other activity in the same cycle, including a push or pop.
- Phase counter: advances only when in_en = 1. Counts 0..DECIM-1, then wraps to 0. Holds when in_en = 0.
- Keep rule: keep = in_en && (phase == 0). The first in_en cycle after reset is kept, then every DECIM-th in_en cycle after it.
- Pop: pop = out_valid && out_ready. out_ready while out_valid = 0 has no effect.
- Push (no pop, not full): on a keep cycle, y_in is written at the write pointer and count increments.
- Push when full:
  - keep && full && pop in the same cycle: the write succeeds, count stays at DEPTH, no overflow.
  - keep && full && !pop: the sample is dropped, overflow is set to 1, and pointers and count are unchanged.
- overflow: sticky; cleared only by reset.
- Simultaneous push and pop when not full: count unchanged; both pointers advance.
- Pointers: wrap modulo DEPTH.
- Output (first-word-fall-through):
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] when count != 0, else 0.
  - out_data must not change while out_valid = 1 and out_ready = 0.
- Latency: a sample kept at clock edge k appears on out_data after edge k, provided the FIFO was empty. There is no same-cycle bypass from y_in to out_data.
- Empty FIFO with push and out_ready = 1: no pop that cycle (out_valid = 0). The sample is visible next cycle.
- Data path: samples pass bit-exact, with no rescaling or sign change; for example 16'h8000 and 16'hFFFF are preserved.
- Ordering: strict FIFO order. No sample is duplicated. The only losses are drops flagged by overflow.

Test Plan:
- Basic decimation: DECIM=4, DEPTH=8, reset released, in_en = 1 every cycle, y_in = 1, 2, 3, ... (one per cycle), out_ready = 1 -> out_data sequence 1, 5, 9, 13, 17; count never exceeds 1; overflow = 0.
- in_en gaps: in_en pattern 1,0,0,1,1,0,1,1,1 with y_in = 10..18 on those cycles -> phase holds on gaps; kept samples are y_in at the 1st and 5th in_en cycles (values 10 and 17).
- Stall to full, then drop: out_ready = 0, 36 consecutive in_en cycles with y_in = 1..36 -> count reaches 8 after the sample 29 is kept; sample 33 is dropped, overflow = 1; draining with out_ready = 1 returns 1, 5, 9, 13, 17, 21, 25, 29, then out_valid = 0.
- Full with push and pop together: FIFO full (count = 8), keep cycle with out_ready = 1 -> count stays 8, overflow stays 0, the new sample is returned last.
- Backpressure stability: out_valid = 1, out_ready = 0 for 5 cycles while pushes continue -> out_data constant; count increments per keep until full.
- Reset mid-operation: count = 5, overflow = 1, phase = 2, then assert reset for 1 cycle -> next cycle count = 0, out_valid = 0, out_data = 0, phase = 0, overflow = 0; the first in_en sample after reset is kept. Also pass y_in = 16'h8000 and 16'hFFFF -> output bit-exact.
